// File: rtl/cmp_dx_sched.sv
// Two-requester scheduler for one duplex magnitude comparator: packs compatible narrow
// compares into a single duplex issue, otherwise round-robins full-width issues.
// Optional counters: define CMP_DX_SCHED_STATS_EN to add stat_pair/stat_single.
module cmp_dx_sched #(
  parameter int WIDTH    = 24,
  parameter int P1_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_tc,
  input  logic             req0_narrow,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_tc,
  input  logic             req1_narrow,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp0_lt,
  output logic             rsp0_eq,
  output logic             rsp0_gt,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic             rsp1_lt,
  output logic             rsp1_eq,
  output logic             rsp1_gt
`ifdef CMP_DX_SCHED_STATS_EN
  ,
  output logic [15:0]      stat_pair,
  output logic [15:0]      stat_single
`endif
);

  localparam int P2_WIDTH = WIDTH - P1_WIDTH;

  // Result encoding {lt, eq, gt}; operands arrive already extended by one bit.
  function automatic logic [2:0] mag_cmp(input logic signed [WIDTH:0] x,
                                         input logic signed [WIDTH:0] y);
    logic [2:0] r;
    r[2] = (x < y);
    r[1] = (x == y);
    r[0] = (x > y);
    return r;
  endfunction

  logic slot0, slot1, elig0, elig1;
  logic pair, grant0, grant1;

  logic [WIDTH-1:0] req0_a_ext, req0_b_ext, req1_a_ext, req1_b_ext;

  logic [WIDTH-1:0] op_a, op_b;
  logic             op_tc, op_dplx;

  logic signed [WIDTH:0] full_a, full_b, p1_a, p1_b, p2_a, p2_b;
  logic [2:0] res_full, res_p1, res_p2, res_rsp0, res_rsp1;

  logic       rsp0_valid_d, rsp0_valid_q, rsp1_valid_d, rsp1_valid_q;
  logic [2:0] rsp0_res_d, rsp0_res_q, rsp1_res_d, rsp1_res_q;
  logic       last_grant_d, last_grant_q;

  // Arbitration
  always_comb begin
    slot0  = !rsp0_valid_q || rsp0_ready;
    slot1  = !rsp1_valid_q || rsp1_ready;
    elig0  = req0_valid && slot0;
    elig1  = req1_valid && slot1;
    pair   = elig0 && elig1 && req0_narrow && req1_narrow && (req0_tc == req1_tc);
    grant0 = pair || (elig0 && (!elig1 || last_grant_q));
    grant1 = pair || (elig1 && (!elig0 || !last_grant_q));
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Unpaired narrow operands widen according to their own signedness.
  always_comb begin
    req0_a_ext = {{P2_WIDTH{req0_tc & req0_a[P1_WIDTH-1]}}, req0_a[P1_WIDTH-1:0]};
    req0_b_ext = {{P2_WIDTH{req0_tc & req0_b[P1_WIDTH-1]}}, req0_b[P1_WIDTH-1:0]};
    req1_a_ext = {{P1_WIDTH{req1_tc & req1_a[P2_WIDTH-1]}}, req1_a[P2_WIDTH-1:0]};
    req1_b_ext = {{P1_WIDTH{req1_tc & req1_b[P2_WIDTH-1]}}, req1_b[P2_WIDTH-1:0]};
  end

  // Operand steering into the shared comparator
  always_comb begin
    op_a    = '0;
    op_b    = '0;
    op_tc   = 1'b0;
    op_dplx = 1'b0;
    if (pair) begin
      op_a    = {req1_a[P2_WIDTH-1:0], req0_a[P1_WIDTH-1:0]};
      op_b    = {req1_b[P2_WIDTH-1:0], req0_b[P1_WIDTH-1:0]};
      op_tc   = req0_tc;
      op_dplx = 1'b1;
    end else if (grant0) begin
      op_a  = req0_narrow ? req0_a_ext : req0_a;
      op_b  = req0_narrow ? req0_b_ext : req0_b;
      op_tc = req0_tc;
    end else if (grant1) begin
      op_a  = req1_narrow ? req1_a_ext : req1_a;
      op_b  = req1_narrow ? req1_b_ext : req1_b;
      op_tc = req1_tc;
    end
  end

  // Duplex comparator: full-width lane plus two independent part lanes
  always_comb begin
    full_a = {op_tc & op_a[WIDTH-1], op_a};
    full_b = {op_tc & op_b[WIDTH-1], op_b};
    p1_a   = {{(P2_WIDTH+1){op_tc & op_a[P1_WIDTH-1]}}, op_a[P1_WIDTH-1:0]};
    p1_b   = {{(P2_WIDTH+1){op_tc & op_b[P1_WIDTH-1]}}, op_b[P1_WIDTH-1:0]};
    p2_a   = {{(P1_WIDTH+1){op_tc & op_a[WIDTH-1]}}, op_a[WIDTH-1:P1_WIDTH]};
    p2_b   = {{(P1_WIDTH+1){op_tc & op_b[WIDTH-1]}}, op_b[WIDTH-1:P1_WIDTH]};
    res_full = mag_cmp(full_a, full_b);
    res_p1   = mag_cmp(p1_a, p1_b);
    res_p2   = mag_cmp(p2_a, p2_b);
    res_rsp0 = op_dplx ? res_p1 : res_full;
    res_rsp1 = op_dplx ? res_p2 : res_full;
  end

  // Response registers and round-robin pointer next state
  always_comb begin
    rsp0_valid_d = rsp0_valid_q;
    rsp0_res_d   = rsp0_res_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_res_d   = rsp1_res_q;
    last_grant_d = last_grant_q;
    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_res_d   = res_rsp0;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end
    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_res_d   = res_rsp1;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
    if (!pair && elig0 && elig1) begin
      last_grant_d = grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_res_q   <= '0;
      rsp1_res_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_res_q   <= rsp0_res_d;
      rsp1_res_q   <= rsp1_res_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign {rsp0_lt, rsp0_eq, rsp0_gt} = rsp0_res_q;
  assign {rsp1_lt, rsp1_eq, rsp1_gt} = rsp1_res_q;

`ifdef CMP_DX_SCHED_STATS_EN
  logic [15:0] stat_pair_d, stat_pair_q, stat_single_d, stat_single_q;

  // Saturating issue counters
  always_comb begin
    stat_pair_d   = stat_pair_q;
    stat_single_d = stat_single_q;
    if (pair && (stat_pair_q != 16'hFFFF)) begin
      stat_pair_d = stat_pair_q + 16'd1;
    end
    if (!pair && (grant0 || grant1) && (stat_single_q != 16'hFFFF)) begin
      stat_single_d = stat_single_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pair_q   <= '0;
      stat_single_q <= '0;
    end else begin
      stat_pair_q   <= stat_pair_d;
      stat_single_q <= stat_single_d;
    end
  end

  assign stat_pair   = stat_pair_q;
  assign stat_single = stat_single_q;
`endif

endmodule

// File: tb/tb_cmp_dx_sched.sv
// Bench for cmp_dx_sched: value-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_cmp_dx_sched;
  localparam int W  = 24;
  localparam int P1 = 16;
  localparam int P2 = W - P1;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req0_tc, req0_narrow;
  logic req1_valid, req1_ready, req1_tc, req1_narrow;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp0_valid, rsp0_ready, rsp0_lt, rsp0_eq, rsp0_gt;
  logic rsp1_valid, rsp1_ready, rsp1_lt, rsp1_eq, rsp1_gt;
`ifdef CMP_DX_SCHED_STATS_EN
  logic [15:0] stat_pair, stat_single;
`endif

  cmp_dx_sched #(.WIDTH(W), .P1_WIDTH(P1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_tc(req0_tc), .req0_narrow(req0_narrow),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_tc(req1_tc), .req1_narrow(req1_narrow),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_lt(rsp0_lt), .rsp0_eq(rsp0_eq), .rsp0_gt(rsp0_gt),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_lt(rsp1_lt), .rsp1_eq(rsp1_eq), .rsp1_gt(rsp1_gt)
`ifdef CMP_DX_SCHED_STATS_EN
    , .stat_pair(stat_pair), .stat_single(stat_single)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Interpret the low n bits of v as an integer (two's complement when tc).
  function automatic longint sval(input logic [W-1:0] v, input int n, input bit tc);
    longint u;
    u = longint'(v) & ((longint'(1) << n) - 1);
    if (tc && u[n-1]) u = u - (longint'(1) << n);
    return u;
  endfunction

  function automatic logic [2:0] mcmp(input longint x, input longint y);
    return {x < y, x == y, x > y};
  endfunction

  // Reference state: held responses, pointer, issue counters.
  bit m_v0 = 0, m_v1 = 0, m_lg = 1;
  logic [2:0] m_r0 = 3'b000, m_r1 = 3'b000;
  int m_sp = 0, m_ss = 0;
  bit n_v0 = 0, n_v1 = 0, n_lg = 1;
  logic [2:0] n_r0 = 3'b000, n_r1 = 3'b000;
  int n_sp = 0, n_ss = 0;

  always @(negedge clk) begin
    bit s0, s1, e0, e1, pr, g0, g1;
    int w0, w1;
    s0 = !m_v0 || rsp0_ready;
    s1 = !m_v1 || rsp1_ready;
    e0 = req0_valid && s0;
    e1 = req1_valid && s1;
    pr = e0 && e1 && req0_narrow && req1_narrow && (req0_tc == req1_tc);
    if (pr) begin
      g0 = 1; g1 = 1;
    end else if (e0 && e1) begin
      g0 = (m_lg == 1); g1 = (m_lg == 0);
    end else begin
      g0 = e0; g1 = e1;
    end
    if (chk_en) begin
      chk("model_req0_ready", {31'd0, req0_ready}, {31'd0, g0});
      chk("model_req1_ready", {31'd0, req1_ready}, {31'd0, g1});
      chk("model_rsp0", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, {28'd0, m_v0, m_r0});
      chk("model_rsp1", {28'd0, rsp1_valid, rsp1_lt, rsp1_eq, rsp1_gt}, {28'd0, m_v1, m_r1});
`ifdef CMP_DX_SCHED_STATS_EN
      chk("model_stat_pair", {16'd0, stat_pair}, m_sp);
      chk("model_stat_single", {16'd0, stat_single}, m_ss);
`endif
    end
    n_v0 = m_v0; n_v1 = m_v1; n_r0 = m_r0; n_r1 = m_r1; n_lg = m_lg; n_sp = m_sp; n_ss = m_ss;
    if (rst) begin
      n_v0 = 0; n_v1 = 0; n_r0 = 0; n_r1 = 0; n_lg = 1; n_sp = 0; n_ss = 0;
    end else begin
      w0 = req0_narrow ? (pr ? P1 : P1) : W;
      w1 = req1_narrow ? P2 : W;
      if (g0) begin
        n_v0 = 1;
        n_r0 = mcmp(sval(req0_a, w0, req0_tc), sval(req0_b, w0, req0_tc));
      end else if (rsp0_ready) n_v0 = 0;
      if (g1) begin
        n_v1 = 1;
        n_r1 = mcmp(sval(req1_a, w1, req1_tc), sval(req1_b, w1, req1_tc));
      end else if (rsp1_ready) n_v1 = 0;
      if (!pr && e0 && e1) n_lg = g1;
      if (pr && m_sp < 65535) n_sp = m_sp + 1;
      if (!pr && (g0 || g1) && m_ss < 65535) n_ss = m_ss + 1;
    end
  end

  always @(posedge clk) begin
    m_v0 = n_v0; m_v1 = n_v1; m_r0 = n_r0; m_r1 = n_r1; m_lg = n_lg; m_sp = n_sp; m_ss = n_ss;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_tc = 0; req0_narrow = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_tc = 0; req1_narrow = 0;
    step(); step();
    rst = 0;
    chk_en = 1;
    chk("reset_rsp0", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, 32'd0);
    chk("reset_rsp1", {28'd0, rsp1_valid, rsp1_lt, rsp1_eq, rsp1_gt}, 32'd0);

    // Full-width unsigned: 0x800000 > 0x7FFFFF
    req0_valid = 1; req0_a = 24'h800000; req0_b = 24'h7FFFFF; req0_tc = 0; req0_narrow = 0;
    settle();
    chk("full_u_ready", {31'd0, req0_ready}, 32'd1);
    step(); req0_valid = 0;
    chk("full_u_result", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, 32'b1001);

    // Same operands signed: -8388608 < 8388607
    req0_valid = 1; req0_tc = 1;
    settle();
    chk("full_s_ready", {31'd0, req0_ready}, 32'd1);
    step(); req0_valid = 0;
    chk("full_s_result", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, 32'b1100);

    // Lone requester 1 is granted regardless of pointer
    req1_valid = 1; req1_a = 24'h000005; req1_b = 24'h000005; req1_tc = 0; req1_narrow = 0;
    settle();
    chk("single_r1_ready", {31'd0, req1_ready}, 32'd1);
    step(); req1_valid = 0;
    chk("single_r1_result", {28'd0, rsp1_valid, rsp1_lt, rsp1_eq, rsp1_gt}, 32'b1010);

    // Pair: upper bits of narrow operands carry junk that must be ignored
    req0_valid = 1; req0_a = 24'hAB0005; req0_b = 24'h120005; req0_tc = 1; req0_narrow = 1;
    req1_valid = 1; req1_a = 24'h3C0080; req1_b = 24'hC30001; req1_tc = 1; req1_narrow = 1;
    settle();
    chk("pair_ready", {30'd0, req0_ready, req1_ready}, 32'b11);
    step(); req0_valid = 0; req1_valid = 0;
    chk("pair_rsp0", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, 32'b1010);
    chk("pair_rsp1", {28'd0, rsp1_valid, rsp1_lt, rsp1_eq, rsp1_gt}, 32'b1100);
`ifdef CMP_DX_SCHED_STATS_EN
    chk("pair_stat", {16'd0, stat_pair}, 32'd1);
`endif

    // tc mismatch: served one at a time, req0 first
    req0_valid = 1; req1_valid = 1; req1_tc = 0;
    settle();
    chk("mism_first", {30'd0, req0_ready, req1_ready}, 32'b10);
    step(); req0_valid = 0;
    settle();
    chk("mism_second", {30'd0, req0_ready, req1_ready}, 32'b01);
    chk("mism_rsp0", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, 32'b1010);
    step(); req1_valid = 0;
    chk("mism_rsp1", {28'd0, rsp1_valid, rsp1_lt, rsp1_eq, rsp1_gt}, 32'b1001);

    // Narrow single signed on req0: 0xFFFF is -1 < 1
    req0_valid = 1; req0_a = 24'h00FFFF; req0_b = 24'hFF0001; req0_tc = 1; req0_narrow = 1;
    settle();
    step(); req0_valid = 0;
    chk("narrow_s_rsp0", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, 32'b1100);

    // Contention from a fresh pointer: grants alternate 0,1,0,1
    rst = 1; step(); rst = 0;
    req0_valid = 1; req0_a = 24'd10; req0_b = 24'd20; req0_tc = 0; req0_narrow = 0;
    req1_valid = 1; req1_a = 24'd30; req1_b = 24'd30; req1_tc = 0; req1_narrow = 0;
    settle();
    for (int i = 0; i < 4; i++) begin
      chk("cont_grant", {30'd0, req0_ready, req1_ready}, (i % 2 == 0) ? 32'b10 : 32'b01);
      step();
      chk("cont_rsp0_valid", {31'd0, rsp0_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_rsp1_valid", {31'd0, rsp1_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    req0_valid = 0; req1_valid = 0;
    step();

    // Backpressure on rsp0, then reset mid-operation
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 24'h000010; req0_b = 24'h000005;
    settle();
    chk("bp_first_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_a = 24'd1; req0_b = 24'd2;
    req1_valid = 1; req1_a = 24'd3; req1_b = 24'd4;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("bp_grant", {30'd0, req0_ready, req1_ready}, 32'b01);
      chk("bp_rsp0_hold", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, 32'b1001);
      step();
    end
    rst = 1;
    step();
    chk("rst_valids", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    rst = 0; rsp0_ready = 1;
    settle();
    chk("post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'b10);
    step(); req0_valid = 0; req1_valid = 0;
    chk("post_rst_rsp0", {28'd0, rsp0_valid, rsp0_lt, rsp0_eq, rsp0_gt}, 32'b1100);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_dx_sched.md
Name: cmp_dx_sched

Overview:
- Scheduler that shares one duplex magnitude comparator between two requesters.
- Narrow compares from both requesters are packed into a single duplex issue when compatible. Otherwise one full-width compare is issued per cycle under round-robin arbitration.
- Results are registered and returned per requester over valid/ready response channels.
- Sits in front of the comparator in compare-heavy datapaths, e.g. sort/select units.

Parameters:
- width, 24, full comparator width in bits (min 4).
- p1_width, 16, width of duplex part 1 (low bits); part 2 width = width-p1_width. Range 2..width-2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid  input  1  requester 0 compare request.
- req0_ready  output  1  request 0 accepted this cycle.
- req0_a, req0_b  input  width  operands.
- req0_tc  input  1  1 = two's complement, 0 = unsigned.
- req0_narrow  input  1  operands significant only in low p1_width bits.
- req1_valid, req1_ready, req1_a, req1_b, req1_tc  as requester 0.
- req1_narrow  input  1  operands significant only in low width-p1_width bits.
- rsp0_valid  output  1  result for requester 0 held.
- rsp0_ready  input  1  requester 0 consumes result.
- rsp0_lt, rsp0_eq, rsp0_gt  output  1 each  a<b, a==b, a>b.
- rsp1_valid, rsp1_ready, rsp1_lt, rsp1_eq, rsp1_gt  as requester 0.

Behaviour:
- Reset: rsp0_valid, rsp1_valid, and all lt/eq/gt outputs are 0. Round-robin pointer last_grant=1, so requester 0 wins first.
- Reset mid-operation discards held and in-flight results. No response is produced for a request accepted in the reset cycle.
- Slot free: slotN = !rspN_valid || rspN_ready.
- Eligible: eligN = reqN_valid && slotN.
- Pair condition: elig0 && elig1 && req0_narrow && req1_narrow && (req0_tc==req1_tc).
- On pair, both readies are asserted in the same cycle and the comparator runs with dplx=1.
  - a = {req1_a[width-p1_width-1:0], req0_a[p1_width-1:0]}; b packed the same way.
  - tc = common tc.
  - Part 1 result goes to rsp0, part 2 result goes to rsp1.
  - last_grant is unchanged.
- Otherwise, if only one requester is eligible, it is granted. If both are eligible, the requester != last_grant wins and last_grant is updated to the winner.
  - The winner is compared with dplx=0 at full width.
  - A narrow, unpaired operand is extended to width before compare: sign-extended if tc=1, zero-extended if tc=0. The narrow bit width is p1_width for req0 and width-p1_width for req1.
- reqN_ready is combinational from the grant and may depend on reqN_valid. A requester holds valid and data stable until ready.
- Latency: an accept on edge N loads rspN_* registers, and rspN_valid is high after edge N. Throughput is 1 compare per cycle, or 2 when paired.
- Response registers:
  - rspN_valid is set on grant and cleared on rspN_ready when no new grant occurs.
  - lt/eq/gt hold stable while rspN_valid=1 && !rspN_ready.
  - Simultaneous drain and grant reloads with rspN_valid staying 1.
- Exactly one of lt/eq/gt is 1 whenever rspN_valid=1.
- Requests with narrow=0 are never paired. A tc mismatch is never paired.

Optional Feature:
- Macro CMP_DX_SCHED_STATS_EN.
- When defined, the block adds two outputs:
  - stat_pair, 16 bits: count of duplex issues.
  - stat_single, 16 bits: count of full-width issues.
- Both counters saturate at 0xFFFF and clear on rst.
- When undefined, these ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Full-width unsigned: req0 a=0x800000, b=0x7FFFFF, tc=0, narrow=0 → req0_ready=1 same cycle; next cycle rsp0_valid=1, gt=1.
- Same operands with tc=1 → rsp0 lt=1. Pointer check: a subsequent single-requester issue is still granted.
- Pair: req0 narrow a=0x0005 b=0x0005; req1 narrow a=0x80 b=0x01; both tc=1 → both readies in the same cycle; rsp0 eq=1, rsp1 lt=1 (−128<1). With STATS_EN, stat_pair=1.
- tc mismatch: same operands with req1_tc=0 → no pairing. Req0 is served first, req1 the next cycle. rsp1 gt=1 (0x80>0x01 unsigned).
- Contention: both valid, full-width, responses always ready, held 4 cycles → grants 0,1,0,1; each rsp valid every other cycle.
- Backpressure then reset: rsp0_ready=0 with rsp0_valid=1 → req0_ready=0 and rsp0 outputs stable while req1 is still granted each cycle. Assert rst → next cycle both rsp valid=0; after release, requester 0 wins first.
